// File: rtl/aes_ecb_sequencer.sv
// Initiator for aes_core_TOP: accepts keys and 128-bit blocks, drives the core init/next handshake,
// and returns each result through a one-entry valid/ready output register.
module aes_ecb_sequencer #(
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         ICLK,
  input  logic         IRST,
  input  logic         IKEY_VALID,
  output logic         OKEY_READY,
  input  logic [255:0] IKEY,
  input  logic         IKEYLEN,
  input  logic         IBLK_VALID,
  output logic         OBLK_READY,
  input  logic [127:0] IBLK,
  input  logic         IENCDEC,
  output logic         ORES_VALID,
  input  logic         IRES_READY,
  output logic [127:0] ORES,
  output logic         OKEY_OK,
  output logic         OERR,
  output logic         OCORE_INIT,
  output logic         OCORE_NEXT,
  output logic [255:0] OCORE_KEY,
  output logic         OCORE_KEYLEN,
  output logic [127:0] OCORE_BLOCK,
  output logic         OCORE_ENCDEC,
  input  logic         ICORE_READY,
  input  logic [127:0] ICORE_RESULT,
  input  logic         ICORE_RESULT_VALID,
  output logic [2:0]   ODBG_STATE
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1; valid is
  // held by the source until then, and ORES/ORES_VALID stay stable until IRES_READY is seen.
  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_PULSE,
    S_INIT_WAITLO,
    S_INIT_WAITHI,
    S_NEXT_PULSE,
    S_NEXT_WAITLO,
    S_NEXT_WAITHI
  } state_e;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT_CYCLES - 1);

  state_e         state_q;
  logic           run_q;
  logic           key_ok_q;
  logic           err_q;
  logic           init_q;
  logic           next_q;
  logic           res_valid_q;
  logic [127:0]   res_q;
  logic [255:0]   key_q;
  logic           keylen_q;
  logic [127:0]   blk_q;
  logic           encdec_q;
  logic [3:0]     pcnt_q;
  logic [9:0]     tcnt_q;

  logic idle;
  logic key_fire;
  logic blk_fire;
  logic tmo;

  // run_q keeps the ready outputs low while reset is applied and for the first cycle after it.
  assign idle       = (state_q == S_IDLE) && run_q;
  assign OKEY_READY = idle;
  assign OBLK_READY = idle && key_ok_q && !res_valid_q && !IKEY_VALID;
  assign key_fire   = IKEY_VALID && OKEY_READY;
  assign blk_fire   = IBLK_VALID && OBLK_READY;
  assign tmo        = (tcnt_q == TMO_LAST);

  always_ff @(posedge ICLK) begin
    if (IRST) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      key_ok_q    <= 1'b0;
      err_q       <= 1'b0;
      init_q      <= 1'b0;
      next_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      key_q       <= '0;
      keylen_q    <= 1'b0;
      blk_q       <= '0;
      encdec_q    <= 1'b0;
      pcnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      run_q <= 1'b1;
      if (res_valid_q && IRES_READY) begin
        res_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (key_fire) begin
            key_q    <= IKEY;
            keylen_q <= IKEYLEN;
            key_ok_q <= 1'b0;
            err_q    <= 1'b0;
            init_q   <= 1'b1;
            pcnt_q   <= '0;
            state_q  <= S_INIT_PULSE;
          end else if (blk_fire) begin
            blk_q    <= IBLK;
            encdec_q <= IENCDEC;
            next_q   <= 1'b1;
            pcnt_q   <= '0;
            state_q  <= S_NEXT_PULSE;
          end
        end
        S_INIT_PULSE, S_NEXT_PULSE: begin
          if (pcnt_q == PULSE_LAST) begin
            init_q  <= 1'b0;
            next_q  <= 1'b0;
            tcnt_q  <= '0;
            state_q <= (state_q == S_INIT_PULSE) ? S_INIT_WAITLO : S_NEXT_WAITLO;
          end else begin
            pcnt_q <= pcnt_q + 4'd1;
          end
        end
        S_INIT_WAITLO, S_NEXT_WAITLO: begin
          if (!ICORE_READY) begin
            tcnt_q  <= '0;
            state_q <= (state_q == S_INIT_WAITLO) ? S_INIT_WAITHI : S_NEXT_WAITHI;
          end else if (tmo) begin
            err_q    <= 1'b1;
            key_ok_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 10'd1;
          end
        end
        S_INIT_WAITHI: begin
          if (ICORE_READY) begin
            key_ok_q <= 1'b1;
            state_q  <= S_IDLE;
          end else if (tmo) begin
            err_q    <= 1'b1;
            key_ok_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 10'd1;
          end
        end
        S_NEXT_WAITHI: begin
          // A ready core without a valid result is not a completion; keep waiting under timeout.
          if (ICORE_READY && ICORE_RESULT_VALID) begin
            res_q       <= ICORE_RESULT;
            res_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (tmo) begin
            err_q    <= 1'b1;
            key_ok_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 10'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ORES_VALID   = res_valid_q;
  assign ORES         = res_q;
  assign OKEY_OK      = key_ok_q;
  assign OERR         = err_q;
  assign OCORE_INIT   = init_q;
  assign OCORE_NEXT   = next_q;
  assign OCORE_KEY    = key_q;
  assign OCORE_KEYLEN = keylen_q;
  assign OCORE_BLOCK  = blk_q;
  assign OCORE_ENCDEC = encdec_q;
  assign ODBG_STATE   = state_q;

endmodule
